dmem_ctrl: RTL

Parametrised data-memory controller for the MIPS datapath. It adds four things to the single-cycle word memory: a request/response handshake, MIPS byte/half/word access with sign or zero extension, misalignment detection, and configurable wait states. After reset it sequentially zeroes the array before accepting traffic. It sits between the MEM stage and the word-wide storage array.

---
 rtl/dmem_pkg.sv | 56 +++++
 rtl/dmem_bank.sv | 31 +++
 rtl/dmem_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory controller.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [1:0] {
    StClear,
    StIdle,
    StWait,
    StResp
  } state_e;

  // Illegal size, or a half/word that does not sit on its natural boundary.
  function automatic logic is_misaligned(logic [1:0] size, logic [1:0] lane);
    logic mis;
    case (size)
      SZ_HALF: mis = lane[0];
      SZ_WORD: mis = (lane != 2'b00);
      SZ_BAD:  mis = 1'b1;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Byte-lane write enables for an aligned access.
  function automatic logic [3:0] lane_mask(logic [1:0] size, logic [1:0] lane);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << lane;
      SZ_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Pull the addressed byte/half out of a little-endian word and extend it.
  function automatic logic [31:0] lane_extract(logic [31:0] word, logic [1:0] lane,
                                               logic [1:0] size, logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: res = {{24{sgn & b[7]}}, b};
      SZ_HALF: res = {{16{sgn & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// DEPTH x 32 storage array with per-byte write enables and a registered read port.
module dmem_bank #(
  parameter int unsigned DEPTH = 128,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [3:0]       i_be,
  input  logic [31:0]      i_wdata,
  input  logic             i_re,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Byte-lane writes; only enabled lanes change.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_be[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
    end
  end

  // Read data is captured on the accept edge and held until the next read.
  always_ff @(posedge i_clk) begin
    if (i_re) r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: handshake, byte/half/word access, alignment check,
// wait states and post-reset clearing of the storage array.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH          = 128,
  parameter int unsigned WAIT_CYCLES    = 0,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  localparam int unsigned ADDR_W        = $clog2(DEPTH) + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e           r_state;
  logic [IDX_W-1:0] r_clr_idx;
  logic [3:0]       r_wait_cnt;
  logic             r_rsp_valid;
  logic             r_err;
  logic             r_load;
  logic [1:0]       r_lane;
  logic [1:0]       r_size;
  logic             r_signed;

  logic             w_accept;
  logic             w_mis;
  logic [IDX_W-1:0] w_idx;
  logic [3:0]       w_be;
  logic [31:0]      w_bwdata;
  logic             w_re;
  logic [31:0]      w_bank_rdata;

  // Gated by rst_n so a request seen during reset never touches memory.
  assign w_accept = rst_n && req_valid && (r_state == StIdle);
  assign w_mis    = is_misaligned(req_size, req_addr[1:0]);

  // Bank port steering: clear writes during CLEAR, request access on the accept edge.
  always_comb begin
    w_idx    = req_addr[ADDR_W-1:2];
    w_be     = 4'b0000;
    w_bwdata = '0;
    w_re     = 1'b0;
    if (rst_n && (r_state == StClear)) begin
      w_idx = r_clr_idx;
      w_be  = 4'b1111;
    end else if (w_accept && !w_mis) begin
      if (req_write) begin
        w_be = lane_mask(req_size, req_addr[1:0]);
        case (req_size)
          SZ_BYTE: w_bwdata = {4{req_wdata[7:0]}};
          SZ_HALF: w_bwdata = {2{req_wdata[15:0]}};
          default: w_bwdata = req_wdata;
        endcase
      end else begin
        w_re = 1'b1;
      end
    end
  end

  dmem_bank #(
    .DEPTH(DEPTH)
  ) u_bank (
    .i_clk  (clk),
    .i_idx  (w_idx),
    .i_be   (w_be),
    .i_wdata(w_bwdata),
    .i_re   (w_re),
    .o_rdata(w_bank_rdata)
  );

  // Control FSM: clear sweep, accept, wait-state count and one-cycle response strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= CLEAR_ON_RESET ? StClear : StIdle;
      r_clr_idx   <= '0;
      r_wait_cnt  <= '0;
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_load      <= 1'b0;
      r_lane      <= 2'b00;
      r_size      <= 2'b00;
      r_signed    <= 1'b0;
    end else begin
      case (r_state)
        StClear: begin
          r_clr_idx <= r_clr_idx + 1'b1;
          if (r_clr_idx == IDX_W'(DEPTH - 1)) r_state <= StIdle;
        end
        StIdle: begin
          if (req_valid) begin
            r_err    <= w_mis;
            r_load   <= !req_write;
            r_lane   <= req_addr[1:0];
            r_size   <= req_size;
            r_signed <= req_signed;
            if (WAIT_CYCLES > 0) begin
              r_state    <= StWait;
              r_wait_cnt <= WAIT_INIT;
            end else begin
              r_state     <= StResp;
              r_rsp_valid <= 1'b1;
            end
          end
        end
        StWait: begin
          if (r_wait_cnt == 4'd0) begin
            r_state     <= StResp;
            r_rsp_valid <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end
        end
        StResp: begin
          r_rsp_valid <= 1'b0;
          r_state     <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_ready = (r_state == StIdle);
  assign busy      = !req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_valid && r_err;
  // Stores and errored requests return zero; loads extend the word read on the accept edge.
  assign rsp_rdata = (r_rsp_valid && r_load && !r_err)
                   ? lane_extract(w_bank_rdata, r_lane, r_size, r_signed) : '0;

endmodule
